pll_reconfig_seq: RTL and testbench
===================================

// Module: pll_reconfig_seq
// PURPOSE
//  Sequences run-time retuning of the video PLL (74.25 MHz pixel / 297 MHz serializer clocks) through the
//  PLL reconfiguration Avalon-MM management port. Requester loads up to MAX_WR register writes (M/N/C/K
//  counters), pulses go; block writes mode, replays the buffered writes, issues start, then waits for relock.
//  Sits between video-mode logic and the reconfig IP; single owner of the mgmt bus.
// PARAMETERS
//  MAX_WR        8        depth of write buffer (power of 2, >=2)
//  LOCK_TIMEOUT  1000000  clk cycles to wait for relock before error (>=2)
// PORTS
//  clk               in   1   sole clock; all logic rising-edge
//  rst_n             in   1   asynchronous active-low reset
//  cfg_valid         in   1   buffer write request
//  cfg_ready         out  1   buffer accepts (idle and not full)
//  cfg_addr          in   6   reconfig register address
//  cfg_data          in   32  reconfig register data
//  go                in   1   start sequence (level sampled, acts on rising cycle only while idle)
//  busy              out  1   sequence in progress
//  done              out  1   1-cycle pulse: sequence finished (check error)
//  error             out  1   sticky: relock timeout / status fail; cleared by next accepted go
//  mgmt_address      out  6   reconfig port address
//  mgmt_write        out  1   write strobe
//  mgmt_writedata    out  32  write data
//  mgmt_read         out  1   read strobe (0 unless PLL_RECFG_VERIFY_EN)
//  mgmt_readdata     in   32  read data
//  mgmt_waitrequest  in   1   slave stall
//  pll_locked        in   1   PLL locked, asynchronous; 2-FF synchronised internally
// BEHAVIOUR
//  Reset: cfg_ready=1, busy=0, done=0, error=0, mgmt_write=0, mgmt_read=0, mgmt_address=0,
//   mgmt_writedata=0; buffer emptied; FSM=IDLE. Reset mid-sequence aborts instantly, no bus completion.
//  Buffer: FIFO, count 0..MAX_WR. Push when cfg_valid&cfg_ready. cfg_ready=(state==IDLE)&&(count<MAX_WR).
//   Full: cfg_ready=0, data held off (no drop). cfg_valid with go same cycle: entry pushed and included.
//  Bus rule: strobe+address+data driven from a registered state; held stable while mgmt_waitrequest=1;
//   transfer completes on cycle strobe&!waitrequest; next transfer may start the following cycle.
//  FSM: IDLE -go-> MODE (write addr 0x00 data 0 = waitrequest mode) -> WR (pop+write each entry, FIFO
//   order) -> START (write addr 0x02 data 1) -> [VERIFY] -> LOCK -> DONE -> IDLE.
//   go with empty buffer: IDLE->DONE directly, no bus activity, done 1 cycle after go, error cleared.
//   LOCK: counter cleared on entry; exit when synced locked=1 (requires 2 consecutive high samples);
//    counter reaches LOCK_TIMEOUT-1 -> error=1, go to DONE. Counter width $clog2(LOCK_TIMEOUT+1).
//  busy=1 in all states except IDLE; done high only in DONE (one cycle). go while busy ignored.
//  Buffer empty at end of every sequence, including error exit.
// CONFIGURATION
//  PLL_RECFG_VERIFY_EN defined: after START, VERIFY state reads addr 0x01 (status); mgmt_read held
//   until !waitrequest; readdata[0]==0 -> error=1, skip LOCK, go to DONE; else LOCK.
//  Undefined: no VERIFY state, START->LOCK; mgmt_read tied 0; mgmt_readdata unused.
// TESTING
//  1 Reset mid-WR (waitrequest=1, mgmt_write=1), release -> all outputs at reset values, cfg_ready=1.
//  2 Push 3 entries (0x03/0x0000_0808,0x04/0x0002_0202,0x05/0x0000_0505), waitrequest=0, locked rises 10
//    cycles after start -> bus sees 0x00/0,0x03,0x04,0x05,0x02/1 in order, done pulse, error=0.
//  3 Push 8 entries -> cfg_ready=0 after 8th, 9th held; go -> 8 writes; after done cfg_ready=1, count 0.
//  4 LOCK_TIMEOUT=16, locked stuck 0 -> done exactly 16 cycles after LOCK entry, error=1; next go clears.
//  5 waitrequest=1 for 5 cycles on each write -> address/data stable while stalled, one transfer each.
//  6 go with empty buffer -> done next cycle, no mgmt strobes; [VERIFY_EN] status readdata=0 -> error=1.

Source files
------------

// File: rtl/pll_reconfig_seq_if.sv
// Bundle of the requester-side and reconfig-management-side signals of the PLL
// reconfiguration sequencer.
//   master modport : sequencer view (takes cfg/go requests, drives the mgmt bus)
//   slave  modport : environment view (video-mode logic, reconfig IP and PLL)
// Signals:
//   cfg_valid/cfg_ready/cfg_addr/cfg_data : write-buffer push handshake
//   go/busy/done/error                    : sequence control and status
//   mgmt_*                                : Avalon-MM reconfig management port
//   pll_locked                            : asynchronous PLL lock indication
interface pll_reconfig_seq_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              go;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mgmt_address;
  logic              mgmt_write;
  logic [DATA_W-1:0] mgmt_writedata;
  logic              mgmt_read;
  logic [DATA_W-1:0] mgmt_readdata;
  logic              mgmt_waitrequest;
  logic              pll_locked;

  modport master (
    input  cfg_valid, cfg_addr, cfg_data, go,
    input  mgmt_readdata, mgmt_waitrequest, pll_locked,
    output cfg_ready, busy, done, error,
    output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read
  );

  modport slave (
    output cfg_valid, cfg_addr, cfg_data, go,
    output mgmt_readdata, mgmt_waitrequest, pll_locked,
    input  cfg_ready, busy, done, error,
    input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// Run-time retuning sequencer for the video PLL. The requester buffers up to
// MAX_WR reconfig register writes and pulses go; the block then writes mode
// (waitrequest mode), replays the buffered writes in FIFO order, writes start
// and waits for the PLL to relock (or times out).
// Optional feature: define PLL_RECFG_VERIFY_EN to read the status register
// after start and abort on a failed status before waiting for lock.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pll_reconfig_seq_if.master (cfg push, go/busy/done/error, mgmt bus,
//           pll_locked)
module pll_reconfig_seq #(
  parameter int unsigned MAX_WR       = 8,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  pll_reconfig_seq_if.master bus
);

  localparam int unsigned PTR_W = $clog2(MAX_WR);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(MAX_WR);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] A_MODE   = 6'h00;
  localparam logic [ADDR_W-1:0] A_STATUS = 6'h01;
  localparam logic [ADDR_W-1:0] A_START  = 6'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_WR, S_START, S_VERIFY, S_LOCK, S_DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] mem_addr [MAX_WR];
  logic [DATA_W-1:0] mem_data [MAX_WR];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_n;

  logic              go_q;
  logic [1:0]        lock_sync;
  logic [TMO_W-1:0]  lock_cnt, lock_cnt_n;

  logic              push_c, pop_c, go_rise_c, xfer_c, locked_c;
  logic              write_n, read_n, error_n;
  logic [ADDR_W-1:0] address_n;
  logic [DATA_W-1:0] writedata_n;

  // Status bits other than bit 0 are never inspected.
  logic unused_rd;
  assign unused_rd = ^bus.mgmt_readdata;

  assign push_c    = bus.cfg_valid & bus.cfg_ready;
  assign go_rise_c = bus.go & ~go_q;
  assign xfer_c    = (bus.mgmt_write | bus.mgmt_read) & ~bus.mgmt_waitrequest;
  assign locked_c  = lock_sync[1];

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      go_q               <= 1'b0;
      lock_sync          <= '0;
      lock_cnt           <= '0;
      bus.cfg_ready      <= 1'b1;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
      bus.mgmt_write     <= 1'b0;
      bus.mgmt_read      <= 1'b0;
      bus.mgmt_address   <= '0;
      bus.mgmt_writedata <= '0;
    end else begin
      state              <= state_n;
      go_q               <= bus.go;
      lock_sync          <= {lock_sync[0], bus.pll_locked};
      lock_cnt           <= lock_cnt_n;
      count              <= count_n;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      bus.cfg_ready      <= (state_n == S_IDLE) && (count_n < FULL);
      bus.busy           <= (state_n != S_IDLE);
      bus.done           <= (state_n == S_DONE);
      bus.error          <= error_n;
      bus.mgmt_write     <= write_n;
      bus.mgmt_read      <= read_n;
      bus.mgmt_address   <= address_n;
      bus.mgmt_writedata <= writedata_n;
    end
  end

  // Buffer storage; occupancy is tracked by the pointers/count above.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_addr[wr_ptr] <= bus.cfg_addr;
      mem_data[wr_ptr] <= bus.cfg_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        // An entry pushed in the go cycle counts toward a non-empty buffer.
        if (go_rise_c) state_n = (count != '0 || push_c) ? S_MODE : S_DONE;
      end
      S_MODE:  if (xfer_c) state_n = S_WR;
      S_WR:    if (xfer_c && count == '0) state_n = S_START;
      S_START: begin
`ifdef PLL_RECFG_VERIFY_EN
        if (xfer_c) state_n = S_VERIFY;
`else
        if (xfer_c) state_n = S_LOCK;
`endif
      end
`ifdef PLL_RECFG_VERIFY_EN
      S_VERIFY: if (xfer_c) state_n = bus.mgmt_readdata[0] ? S_LOCK : S_DONE;
`endif
      S_LOCK:  if (locked_c || lock_cnt == TMO_LAST) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of bus strobes, error, lock counter and buffer pop.
  always_comb begin
    pop_c       = 1'b0;
    write_n     = bus.mgmt_write;
    read_n      = bus.mgmt_read;
    address_n   = bus.mgmt_address;
    writedata_n = bus.mgmt_writedata;
    error_n     = bus.error;
    lock_cnt_n  = lock_cnt;
    case (state)
      S_IDLE: begin
        if (go_rise_c) begin
          error_n = 1'b0;
          if (state_n == S_MODE) begin
            write_n     = 1'b1;
            address_n   = A_MODE;
            writedata_n = '0;
          end
        end
      end
      S_MODE: begin
        // Mode write done: present the head entry next cycle, write stays high.
        if (xfer_c) begin
          pop_c       = 1'b1;
          address_n   = mem_addr[rd_ptr];
          writedata_n = mem_data[rd_ptr];
        end
      end
      S_WR: begin
        if (xfer_c) begin
          if (count != '0) begin
            pop_c       = 1'b1;
            address_n   = mem_addr[rd_ptr];
            writedata_n = mem_data[rd_ptr];
          end else begin
            address_n   = A_START;
            writedata_n = DATA_W'(1);
          end
        end
      end
      S_START: begin
        if (xfer_c) begin
          write_n    = 1'b0;
          lock_cnt_n = '0;
`ifdef PLL_RECFG_VERIFY_EN
          read_n      = 1'b1;
          address_n   = A_STATUS;
          writedata_n = '0;
`endif
        end
      end
`ifdef PLL_RECFG_VERIFY_EN
      S_VERIFY: begin
        if (xfer_c) begin
          read_n     = 1'b0;
          lock_cnt_n = '0;
          if (!bus.mgmt_readdata[0]) error_n = 1'b1;
        end
      end
`endif
      S_LOCK: begin
        if (!locked_c) begin
          if (lock_cnt == TMO_LAST) error_n = 1'b1;
          else lock_cnt_n = lock_cnt + TMO_W'(1);
        end
      end
      default: ;
    endcase

    count_n = count;
    if (push_c && !pop_c)      count_n = count + CNT_W'(1);
    else if (!push_c && pop_c) count_n = count - CNT_W'(1);
  end

  // Status address is only referenced by the verify read.
  logic [ADDR_W-1:0] unused_status_addr;
  assign unused_status_addr = A_STATUS;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table of full sequences plus hand-written
// reset, full-buffer, empty-go and push-with-go sequences.
module tb_pll_reconfig_seq;
  localparam int unsigned MAX_WR       = 8;
  localparam int unsigned LOCK_TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_reconfig_seq_if bus();

  pll_reconfig_seq #(.MAX_WR(MAX_WR), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [37:0] cap_q[$];
  logic [37:0] exp_q[$];
  logic [5:0]  ea [8];
  logic [31:0] ed [8];

  // Management slave model and bus monitor.
  int          stall_cfg  = 0;
  int          st_cnt     = 0;
  int          strobe_cnt = 0;
  bit          mon_en     = 1'b0;
  bit          prev_stall = 1'b0;
  logic [38:0] prev_bus;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && prev_stall) begin
      checks++;
      if ({bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata} !== prev_bus) begin
        errors++;
        $display("FAIL stall_stable: got %0h, expected %0h",
                 {bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata}, prev_bus);
      end
    end
    if (bus.mgmt_write === 1'b1 || bus.mgmt_read === 1'b1) begin
      strobe_cnt++;
      if (st_cnt < stall_cfg) begin
        bus.mgmt_waitrequest = 1'b1;
        st_cnt++;
        prev_stall = 1'b1;
        prev_bus   = {bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata};
      end else begin
        bus.mgmt_waitrequest = 1'b0;
        st_cnt     = 0;
        prev_stall = 1'b0;
        if (bus.mgmt_write === 1'b1) cap_q.push_back({bus.mgmt_address, bus.mgmt_writedata});
      end
    end else begin
      bus.mgmt_waitrequest = 1'b0;
      st_cnt     = 0;
      prev_stall = 1'b0;
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    while (!acc && k < 50) begin
      acc = bus.cfg_ready;
      cyc1();
      k++;
    end
    bus.cfg_valid = 1'b0;
    chk("push_accepted", 64'(acc), 64'(1));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) push(ea[i], ed[i]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(1));
    chk({tag, "_busy"},      64'(bus.busy), 64'(0));
    chk({tag, "_done"},      64'(bus.done), 64'(0));
    chk({tag, "_error"},     64'(bus.error), 64'(0));
    chk({tag, "_mwrite"},    64'(bus.mgmt_write), 64'(0));
    chk({tag, "_mread"},     64'(bus.mgmt_read), 64'(0));
    chk({tag, "_maddr"},     64'(bus.mgmt_address), 64'(0));
    chk({tag, "_mdata"},     64'(bus.mgmt_writedata), 64'(0));
  endtask

  // Pulse go, wait for done and compare the captured write sequence.
  task automatic go_and_wait(input int n, input bit with_push, input bit lock_ok,
                             input bit exp_err, input int exp_lock);
    int  cyc;
    int  start_cyc;
    bit  got_done;
    exp_q.delete();
    cap_q.delete();
    exp_q.push_back({6'h00, 32'h0});
    for (int i = 0; i < n; i++) exp_q.push_back({ea[i], ed[i]});
    exp_q.push_back({6'h02, 32'h1});
    if (with_push) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = ea[0];
      bus.cfg_data  = ed[0];
    end
    bus.go = 1'b1;
    cyc1();
    bus.go        = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("busy_after_go", 64'(bus.busy), 64'(1));
    chk("error_cleared_by_go", 64'(bus.error), 64'(0));
    chk("ready_low_while_busy", 64'(bus.cfg_ready), 64'(0));
    cyc       = 0;
    start_cyc = -1;
    got_done  = 1'b0;
    while (!got_done && cyc < 2000) begin
      cyc1();
      cyc++;
      if (start_cyc < 0 && cap_q.size() == n + 2) start_cyc = cyc;
      if (lock_ok && start_cyc >= 0 && cyc - start_cyc == 10) bus.pll_locked = 1'b1;
      got_done = bus.done;
    end
    chk("done_seen", 64'(got_done), 64'(1));
    if (got_done) begin
      chk("lock_latency", 64'(cyc - start_cyc), 64'(exp_lock));
      chk("error_at_done", 64'(bus.error), 64'(exp_err));
      chk("busy_at_done", 64'(bus.busy), 64'(1));
      chk("write_count", 64'(cap_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
        chk("write_addr_data", 64'(cap_q[i]), 64'(exp_q[i]));
    end
    bus.pll_locked = 1'b0;
    cyc1();
    chk("done_one_cycle", 64'(bus.done), 64'(0));
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("idle_ready", 64'(bus.cfg_ready), 64'(1));
    chk("error_sticky", 64'(bus.error), 64'(exp_err));
    repeat (3) cyc1();
  endtask

  typedef struct {
    int n;
    int stall;
    bit lock_ok;
    bit exp_err;
    int exp_lock;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k;
    int s0;
    ea = '{6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};
    ed = '{32'h0000_0808, 32'h0002_0202, 32'h0000_0505, 32'h1111_0006,
           32'h2222_0007, 32'h3333_0008, 32'h4444_0009, 32'h5555_000A};
    // lock_ok: locked asserted 10 cycles into LOCK, 2-FF sync + registered done -> 13
    // timeout: LOCK_TIMEOUT cycles after LOCK entry -> 16
    vecs[0] = '{n: 3, stall: 0, lock_ok: 1'b1, exp_err: 1'b0, exp_lock: 13};
    vecs[1] = '{n: 8, stall: 0, lock_ok: 1'b1, exp_err: 1'b0, exp_lock: 13};
    vecs[2] = '{n: 2, stall: 5, lock_ok: 1'b1, exp_err: 1'b0, exp_lock: 13};
    vecs[3] = '{n: 4, stall: 2, lock_ok: 1'b1, exp_err: 1'b0, exp_lock: 13};
    vecs[4] = '{n: 1, stall: 0, lock_ok: 1'b0, exp_err: 1'b1, exp_lock: 16};

    bus.cfg_valid     = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_data      = '0;
    bus.go            = 1'b0;
    bus.pll_locked    = 1'b0;
    bus.mgmt_readdata = 32'h1;

    // Power-on reset.
    repeat (2) cyc1();
    check_reset_values("por");
    rst_n = 1'b1;
    cyc1();
    mon_en = 1'b1;
    check_reset_values("post_por");

    // Table of complete sequences; the last one times out.
    for (int v = 0; v < 5; v++) begin
      stall_cfg = vecs[v].stall;
      fill(vecs[v].n);
      go_and_wait(vecs[v].n, 1'b0, vecs[v].lock_ok, vecs[v].exp_err, vecs[v].exp_lock);
    end
    stall_cfg = 0;

    // go with empty buffer: done next cycle, no bus strobes, sticky error cleared.
    chk("error_still_set", 64'(bus.error), 64'(1));
    cap_q.delete();
    s0 = strobe_cnt;
    bus.go = 1'b1;
    cyc1();
    bus.go = 1'b0;
    chk("empty_done", 64'(bus.done), 64'(1));
    chk("empty_busy", 64'(bus.busy), 64'(1));
    chk("empty_error_clr", 64'(bus.error), 64'(0));
    cyc1();
    chk("empty_done_pulse", 64'(bus.done), 64'(0));
    chk("empty_idle", 64'(bus.busy), 64'(0));
    chk("empty_no_strobe", 64'(strobe_cnt - s0), 64'(0));

    // Full buffer holds off the 9th entry; only 8 writes replayed.
    fill(8);
    chk("full_ready_low", 64'(bus.cfg_ready), 64'(0));
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 6'h3F;
    bus.cfg_data  = 32'hDEAD_BEEF;
    repeat (3) begin
      cyc1();
      chk("full_hold_off", 64'(bus.cfg_ready), 64'(0));
    end
    bus.cfg_valid = 1'b0;
    go_and_wait(8, 1'b0, 1'b1, 1'b0, 13);

    // cfg_valid in the go cycle on an empty buffer: entry included.
    go_and_wait(1, 1'b1, 1'b1, 1'b0, 13);

    // Reset while a buffered write is stalled.
    fill(3);
    bus.go = 1'b1;
    cyc1();
    bus.go = 1'b0;
    k = 0;
    while (!(bus.mgmt_write === 1'b1 && bus.mgmt_address === ea[0]) && k < 20) begin
      cyc1();
      k++;
    end
    stall_cfg = 1000;
    cyc1();
    chk("midwr_write", 64'(bus.mgmt_write), 64'(1));
    chk("midwr_addr", 64'(bus.mgmt_address), 64'(ea[0]));
    chk("midwr_wait", 64'(bus.mgmt_waitrequest), 64'(1));
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_values("midwr_rst");
    cyc1();
    rst_n     = 1'b1;
    stall_cfg = 0;
    repeat (2) cyc1();
    check_reset_values("midwr_rel");
    mon_en = 1'b1;
    // Buffer must have been emptied: go finishes immediately with no strobes.
    s0 = strobe_cnt;
    bus.go = 1'b1;
    cyc1();
    bus.go = 1'b0;
    chk("rst_empty_done", 64'(bus.done), 64'(1));
    cyc1();
    chk("rst_empty_no_strobe", 64'(strobe_cnt - s0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
